fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined CPU.
- Owns the PC and the PC+2 increment, and issues requests to instruction memory over a req/ack handshake.
- Loads the IF/ID pipeline register that feeds control, RegFile and SignExtension.
- Takes stall requests from HazardDetection and branch redirects from BranchLogic/BL_add; one-entry skid buffer absorbs a fetch that returns during a stall.

Parameters:
ADDR_W, 8, PC / instruction-address width
INSTR_W, 16, instruction width
PC_STEP, 2, PC increment per instruction (byte addressed)
RESET_PC, 8'h00, PC after reset
NOP_INSTR, 16'h0000, value loaded into IF/ID on bubble/flush

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
im_req  out  1  fetch request to instruction memory
im_addr  out  ADDR_W  fetch address, stable while im_req=1 until im_ack
im_ack  in  1  memory response; im_rdata valid in the same cycle
im_rdata  in  INSTR_W  fetched instruction
stall  in  1  hold PC and IF/ID (HazardDetection, PCWrite/IFID_Write low)
branch_taken  in  1  redirect fetch (PCSRC)
branch_target  in  ADDR_W  redirect address
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  INSTR_W  IF/ID instruction
ifid_pc  out  ADDR_W  address of ifid_instr
ifid_pc_plus  out  ADDR_W  ifid_pc + PC_STEP (mod 2^ADDR_W)
ifid_opcode  out  4  ifid_instr[15:12]
ifid_fop1  out  4  ifid_instr[11:8]
ifid_fop2  out  4  ifid_instr[7:4]
ifid_funct  out  4  ifid_instr[3:0]
ifid_offset  out  12  ifid_instr[11:0]

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, req_addr=RESET_PC, hold_valid=0.
  - ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0.
  - im_req=0 immediately. An abandoned memory request is dropped; memory must tolerate this.
- Decode fields are combinational slices of ifid_instr. ifid_pc_plus = ifid_pc+PC_STEP, combinational.
- States:
  - IDLE: im_req=0 for exactly one cycle after reset release, then FETCH.
  - FETCH: im_req = !hold_valid; im_addr = req_addr (= pc).
  - KILL: im_req=1, im_addr = req_addr (the squashed address), pc = redirect target. On im_ack: discard im_rdata, req_addr<=pc, go to FETCH.
- Every edge, priority order: branch_taken, then stall, then normal.
- branch_taken=1 (any state except IDLE):
  - pc <= req_addr <= {branch_target[ADDR_W-1:1],1'b0} (bit0 forced to 0).
  - IF/ID flushed: ifid_valid<=0, ifid_instr<=NOP_INSTR. hold_valid<=0.
  - In FETCH with request outstanding and im_ack=0: pc <= target, req_addr unchanged, go to KILL.
  - im_ack=1 in the same cycle: data discarded, stay in FETCH at target.
  - In KILL: target overwrites pc, stay in KILL.
- stall=1, no branch:
  - IF/ID holds.
  - FETCH, hold empty, im_ack=1: hold<={im_rdata,req_addr}, hold_valid<=1, pc<=req_addr<=pc+PC_STEP.
  - im_req stays 0 while hold_valid=1.
- stall=0, no branch:
  - hold_valid=1: IF/ID<=hold, ifid_valid<=1, hold_valid<=0. Next request is issued the following cycle.
  - Else FETCH with im_ack=1: ifid_instr<=im_rdata, ifid_pc<=req_addr, ifid_valid<=1, pc<=req_addr<=pc+PC_STEP.
  - Else: bubble (ifid_valid<=0, ifid_instr<=NOP_INSTR).
- Throughput and latency:
  - Zero-wait memory (ack in request cycle) gives 1 instruction/cycle.
  - Fetch-to-IF/ID latency is 1 edge after ack.
- PC wraps modulo 2^ADDR_W: 8'hFE + 2 = 8'h00, with no flag.
- stall and branch_taken together: branch wins; the flush overrides the hold.
- im_ack while im_req=0 (IDLE, or hold full): ignored.

Test Plan:
1. Reset release, zero-wait memory returning 16'h1000+addr:
   - im_req rises 1 cycle after release; IF/ID shows pc 00,02,04 on successive edges.
   - ifid_instr 1000,1002,1004; ifid_valid=1 from edge 2.
2. 2-cycle memory latency:
   - im_addr holds 8'h04 until ack.
   - Bubble (ifid_valid=0, NOP) inserted for each wait cycle.
3. stall=1 for 3 cycles with ack arriving in the first stall cycle:
   - IF/ID frozen; hold captures addr 06; im_req=0 on the remaining cycles.
   - Stall release: IF/ID=instr@06; next im_addr=08.
4. Branch redirect:
   - branch_taken=1, target=8'h41 while request to 0A is pending (no ack): state=KILL, IF/ID flushed.
   - Late ack for 0A is discarded; the next request is to 8'h40.
5. Wrap-around: run PC to 8'hFE → next im_addr=8'h00 with ifid_pc_plus(FE)=00. Also drive branch+stall in the same cycle → branch taken, hold cleared.
6. Reset mid-operation:
   - Assert reset with hold_valid=1 and the request outstanding.
   - Without waiting for a clock edge: im_req=0, ifid_valid=0, and pc=00 immediately.
   - Restart fetches from 00.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PC/PC+2, drives the IM req/ack handshake and loads IF/ID.
// Latency: an instruction appears in IF/ID one edge after its im_ack (1 instr/cycle with zero-wait memory).
// Backpressure: stall freezes IF/ID; one fetch returning during a stall is parked in a one-entry hold buffer.
//
// Ports:
//   clk, reset (async, active-low)
//   im_req/im_addr/im_ack/im_rdata : instruction-memory handshake
//   stall, branch_taken, branch_target : hazard stall and branch redirect
//   ifid_* : IF/ID register contents plus combinational decode slices
module fetch_stage #(
  parameter int                   ADDR_W    = 8,
  parameter int                   INSTR_W   = 16,
  parameter int                   PC_STEP   = 2,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               im_req,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_plus,
  output logic [3:0]         ifid_opcode,
  output logic [3:0]         ifid_fop1,
  output logic [3:0]         ifid_fop2,
  output logic [3:0]         ifid_funct,
  output logic [11:0]        ifid_offset
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_KILL} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [INSTR_W-1:0]   hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0]    hold_pc_q, hold_pc_d;
  logic                 ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]    ifid_pc_q, ifid_pc_d;

  logic                 ack_acc;
  logic [ADDR_W-1:0]    tgt;

  // Instructions are halfword aligned, so the redirect target's bit 0 is dropped.
  assign tgt = branch_target & ~ADDR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;

    case (state_q)
      S_FETCH: im_req = !hold_valid_q;
      S_KILL:  im_req = 1'b1;
      default: im_req = 1'b0;
    endcase
    // Acks while no request is up (IDLE, hold full) are ignored.
    ack_acc = im_ack && im_req;

    if (state_q == S_IDLE) begin
      state_d = S_FETCH;
    end else if (branch_taken) begin
      pc_d         = tgt;
      hold_valid_d = 1'b0;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      if (im_req && !im_ack) begin
        // Request still in flight: keep presenting it until memory answers, then discard.
        state_d = S_KILL;
      end else begin
        req_addr_d = tgt;
        state_d    = S_FETCH;
      end
    end else if (state_q == S_KILL) begin
      if (ack_acc) begin
        req_addr_d = pc_q;
        state_d    = S_FETCH;
      end
      if (!stall) begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
      end
    end else if (stall) begin
      if (ack_acc) begin
        hold_valid_d = 1'b1;
        hold_instr_d = im_rdata;
        hold_pc_d    = req_addr_q;
        pc_d         = pc_q + STEP;
        req_addr_d   = pc_q + STEP;
      end
    end else if (hold_valid_q) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = hold_instr_q;
      ifid_pc_d    = hold_pc_q;
      hold_valid_d = 1'b0;
    end else if (ack_acc) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = im_rdata;
      ifid_pc_d    = req_addr_q;
      pc_d         = pc_q + STEP;
      req_addr_d   = pc_q + STEP;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end
  end

  assign im_addr      = req_addr_q;
  assign ifid_valid   = ifid_valid_q;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_pc      = ifid_pc_q;
  assign ifid_pc_plus = ifid_pc_q + STEP;
  assign ifid_opcode  = ifid_instr_q[15:12];
  assign ifid_fop1    = ifid_instr_q[11:8];
  assign ifid_fop2    = ifid_instr_q[7:4];
  assign ifid_funct   = ifid_instr_q[3:0];
  assign ifid_offset  = ifid_instr_q[11:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model returns 16'h1000+addr after a programmable wait.
// Expected IF/ID entries are queued by the directed steps and popped as IF/ID loads new instructions.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        im_req;
  logic [7:0]  im_addr;
  logic        im_ack;
  logic [15:0] im_rdata;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic [7:0]  ifid_pc_plus;
  logic [3:0]  ifid_opcode;
  logic [3:0]  ifid_fop1;
  logic [3:0]  ifid_fop2;
  logic [3:0]  ifid_funct;
  logic [11:0] ifid_offset;

  int errors = 0;
  int checks = 0;

  int   lat = 0;
  logic mem_hold = 1'b0;
  int   wcnt;

  logic [23:0] sb[$];
  logic        st_e, br_e;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus(ifid_pc_plus), .ifid_opcode(ifid_opcode), .ifid_fop1(ifid_fop1),
    .ifid_fop2(ifid_fop2), .ifid_funct(ifid_funct), .ifid_offset(ifid_offset)
  );

  // Instruction memory: answers after `lat` wait cycles unless mem_hold is set.
  assign im_ack   = im_req && !mem_hold && (wcnt >= lat);
  assign im_rdata = 16'h1000 + 16'(im_addr);

  always @(posedge clk or negedge reset) begin
    if (!reset) wcnt <= 0;
    else if (im_req && !im_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] pc);
    sb.push_back({pc, 16'h1000 + 16'(pc)});
  endtask

  // A new IF/ID entry appears on any edge that was not a plain stall.
  always @(posedge clk) begin
    st_e = stall;
    br_e = branch_taken;
    @(negedge clk);
    if (reset && ifid_valid && !(st_e && !br_e)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {8'h0, ifid_pc, ifid_instr}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        chk("sb_entry", {8'h0, ifid_pc, ifid_instr}, {8'h0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_im_req", 32'(im_req), 0);
    chk("rst_im_addr", 32'(im_addr), 0);
    chk("rst_ifid_valid", 32'(ifid_valid), 0);
    chk("rst_ifid_instr", 32'(ifid_instr), 0);
    chk("rst_ifid_pc", 32'(ifid_pc), 0);

    // 1: zero-wait fetch after reset release
    push(8'h00); push(8'h02); push(8'h04); push(8'h06); push(8'h08);
    reset = 1'b1;
    #1 chk("idle_im_req", 32'(im_req), 0);
    @(negedge clk);
    chk("t1_req_rise", 32'(im_req), 1);
    chk("t1_addr0", 32'(im_addr), 32'h00);
    chk("t1_valid0", 32'(ifid_valid), 0);
    @(negedge clk);
    chk("t1_valid1", 32'(ifid_valid), 1);
    chk("t1_pc00", 32'(ifid_pc), 32'h00);
    chk("t1_instr00", 32'(ifid_instr), 32'h1000);
    chk("t1_addr02", 32'(im_addr), 32'h02);
    @(negedge clk);
    chk("t1_pc02", 32'(ifid_pc), 32'h02);
    chk("t1_addr04", 32'(im_addr), 32'h04);

    // 2: two wait cycles on the fetch of 04
    lat = 2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t2_hold_addr", 32'(im_addr), 32'h04);
      chk("t2_req", 32'(im_req), 1);
      chk("t2_bubble_v", 32'(ifid_valid), 0);
      chk("t2_bubble_i", 32'(ifid_instr), 32'h0000);
    end
    lat = 0;
    @(negedge clk);
    chk("t2_pc04", 32'(ifid_pc), 32'h04);
    chk("t2_addr06", 32'(im_addr), 32'h06);

    // 3: stall three cycles, fetch of 06 lands in the hold buffer
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_req_off", 32'(im_req), 0);
      chk("t3_frozen_pc", 32'(ifid_pc), 32'h04);
      chk("t3_frozen_v", 32'(ifid_valid), 1);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("t3_hold_pc", 32'(ifid_pc), 32'h06);
    chk("t3_hold_instr", 32'(ifid_instr), 32'h1006);
    chk("t3_next_addr", 32'(im_addr), 32'h08);
    chk("t3_next_req", 32'(im_req), 1);
    @(negedge clk);
    chk("t3_pc08", 32'(ifid_pc), 32'h08);
    chk("t3_addr0a", 32'(im_addr), 32'h0A);

    // 4: redirect while 0A is outstanding, late ack must be discarded
    mem_hold = 1'b1;
    branch_taken = 1'b1;
    branch_target = 8'h41;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("t4_flush_v", 32'(ifid_valid), 0);
    chk("t4_flush_i", 32'(ifid_instr), 32'h0000);
    chk("t4_kill_addr", 32'(im_addr), 32'h0A);
    chk("t4_kill_req", 32'(im_req), 1);
    @(negedge clk);
    chk("t4_kill_addr2", 32'(im_addr), 32'h0A);
    mem_hold = 1'b0;
    push(8'h40);
    @(negedge clk);
    chk("t4_redir_addr", 32'(im_addr), 32'h40);
    chk("t4_discard_v", 32'(ifid_valid), 0);
    @(negedge clk);
    chk("t4_pc40", 32'(ifid_pc), 32'h40);

    // 5: wrap-around, then branch and stall together
    branch_taken = 1'b1;
    branch_target = 8'hFA;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("t5_redir_fa", 32'(im_addr), 32'hFA);
    chk("t5_flush_v", 32'(ifid_valid), 0);
    push(8'hFA); push(8'hFC); push(8'hFE); push(8'h00);
    repeat (3) @(negedge clk);
    chk("t5_pc_fe", 32'(ifid_pc), 32'hFE);
    chk("t5_pc_plus_wrap", 32'(ifid_pc_plus), 32'h00);
    chk("t5_addr_wrap", 32'(im_addr), 32'h00);
    chk("t5_opcode", 32'(ifid_opcode), 32'h1);
    chk("t5_fop1", 32'(ifid_fop1), 32'h0);
    chk("t5_fop2", 32'(ifid_fop2), 32'hF);
    chk("t5_funct", 32'(ifid_funct), 32'hE);
    chk("t5_offset", 32'(ifid_offset), 32'h0FE);
    @(negedge clk);
    chk("t5_pc00", 32'(ifid_pc), 32'h00);
    chk("t5_addr02", 32'(im_addr), 32'h02);
    stall = 1'b1;
    @(negedge clk);
    chk("t5_holdfull_req", 32'(im_req), 0);
    branch_taken = 1'b1;
    branch_target = 8'h20;
    @(negedge clk);
    branch_taken = 1'b0;
    stall = 1'b0;
    chk("t5_bs_flush", 32'(ifid_valid), 0);
    chk("t5_bs_req", 32'(im_req), 1);
    chk("t5_bs_addr", 32'(im_addr), 32'h20);
    push(8'h20);
    @(negedge clk);
    chk("t5_pc20", 32'(ifid_pc), 32'h20);

    // 6: asynchronous reset with the hold buffer full
    stall = 1'b1;
    @(negedge clk);
    chk("t6_holdfull", 32'(im_req), 0);
    chk("t6_valid_pre", 32'(ifid_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_req", 32'(im_req), 0);
    chk("t6_async_v", 32'(ifid_valid), 0);
    chk("t6_async_pc", 32'(im_addr), 32'h00);
    chk("t6_async_i", 32'(ifid_instr), 32'h0000);
    @(negedge clk);
    stall = 1'b0;
    push(8'h00); push(8'h02);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_restart_req", 32'(im_req), 1);
    chk("t6_restart_addr", 32'(im_addr), 32'h00);
    @(negedge clk);
    chk("t6_pc00", 32'(ifid_pc), 32'h00);
    @(negedge clk);
    chk("t6_pc02", 32'(ifid_pc), 32'h02);
    mem_hold = 1'b1;
    @(negedge clk);
    chk("t6_bubble", 32'(ifid_valid), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
